// File: rtl/battleship_pkg.sv
// Shared types, board geometry and helpers for the battleship game controller.
package battleship_pkg;

  localparam int BOARD_SIZE = 5;
  localparam int CELLS      = BOARD_SIZE * BOARD_SIZE;
  localparam int MAX_SHIPS  = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLACE  = 3'd1,
    ST_PLAYER = 3'd2,
    ST_CPU    = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_CPU    = 2'b10;

  // Bit positions inside the packed button vector fed to the edge detector
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;
  localparam int BTN_W     = 5;

  // Row-major cell index; 5 bits holds every index of the 5x5 board.
  function automatic logic [4:0] cell_idx(input logic [2:0] i, input logic [2:0] j);
    return 5'(i) * 5'(BOARD_SIZE) + 5'(j);
  endfunction

  // A game needs at least one ship and never more than the board allows.
  function automatic logic [2:0] clamp_ships(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > 3'(MAX_SHIPS)) return 3'(MAX_SHIPS);
    return n;
  endfunction

endpackage

// File: rtl/battleship_game_ctrl_btn_edge.sv
// Falling-edge detector for active-low buttons: one press pulse per push.
module btn_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn_n_i,
  output logic [W-1:0] press_o
);

  logic [W-1:0] prev_q;

  // Remember last sample; reset to released so nothing fires out of reset
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '1;
    else     prev_q <= btn_n_i;
  end

  assign press_o = prev_q & ~btn_n_i;

endmodule

// File: rtl/battleship_game_ctrl.sv
// Game sequencer: cursor, ship placement, alternating turns, hits, game over.
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int TURN_SECS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        btn_select,
  input  logic        start,
  input  logic [2:0]  amount_of_ships,
  input  logic        sec_tick,
  input  logic [24:0] enemy_map,
  input  logic        cpu_valid,
  input  logic [2:0]  cpu_i,
  input  logic [2:0]  cpu_j,
  output logic        cpu_ready,
  output logic [2:0]  i_cursor,
  output logic [2:0]  j_cursor,
  output logic [2:0]  ships_placed,
  output logic [24:0] own_map,
  output logic [24:0] shot_map,
  output logic [24:0] cpu_shot_map,
  output logic [2:0]  player_hits,
  output logic [2:0]  cpu_hits,
  output logic [3:0]  turn_timer,
  output logic [2:0]  state,
  output logic [1:0]  winner,
  output logic        err_pulse
);

  logic [BTN_W-1:0] press;
  state_t      state_q, state_d;
  logic [2:0]  count_q, count_d, i_q, i_d, j_q, j_d, placed_q, placed_d;
  logic [2:0]  phits_q, phits_d, chits_q, chits_d, hits_new;
  logic [24:0] own_q, own_d, shot_q, shot_d, cshot_q, cshot_d;
  logic [3:0]  timer_q, timer_d;
  logic [1:0]  win_q, win_d;
  logic        err_q, err_d, rdy_q, rdy_d;
  logic [4:0]  cur_idx, cpu_idx;

  btn_edge #(.W(BTN_W)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i ({btn_select, move_right, move_left, move_down, move_up}),
    .press_o (press)
  );

  assign cur_idx = cell_idx(i_q, j_q);
  assign cpu_idx = cell_idx(cpu_i, cpu_j);

  // Next-state logic for the game FSM and all datapath registers
  always_comb begin
    state_d  = state_q;  count_d  = count_q;  i_d     = i_q;     j_d     = j_q;
    placed_d = placed_q; phits_d  = phits_q;  chits_d = chits_q; own_d   = own_q;
    shot_d   = shot_q;   cshot_d  = cshot_q;  timer_d = timer_q; win_d   = win_q;
    err_d    = 1'b0;     hits_new = 3'd0;

    // Cursor saturates at the board edges; opposing presses cancel out
    if (state_q == ST_PLACE || state_q == ST_PLAYER) begin
      if (press[BTN_DOWN] && !press[BTN_UP] && i_q != 3'(BOARD_SIZE - 1)) i_d = i_q + 3'd1;
      if (press[BTN_UP] && !press[BTN_DOWN] && i_q != 3'd0)               i_d = i_q - 3'd1;
      if (press[BTN_RIGHT] && !press[BTN_LEFT] && j_q != 3'(BOARD_SIZE - 1)) j_d = j_q + 3'd1;
      if (press[BTN_LEFT] && !press[BTN_RIGHT] && j_q != 3'd0)             j_d = j_q - 3'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d  = clamp_ships(amount_of_ships);
          i_d      = 3'd0;  j_d     = 3'd0;  placed_d = 3'd0;
          phits_d  = 3'd0;  chits_d = 3'd0;  own_d    = '0;
          shot_d   = '0;    cshot_d = '0;    timer_d  = 4'd0;
          win_d    = WIN_NONE;
          state_d  = ST_PLACE;
        end
      end
      ST_PLACE: begin
        if (press[BTN_SEL]) begin
          if (own_q[cur_idx]) begin
            err_d = 1'b1;
          end else begin
            own_d[cur_idx] = 1'b1;
            placed_d       = placed_q + 3'd1;
            if (placed_d == count_q) begin
              state_d = ST_PLAYER;
              timer_d = 4'(TURN_SECS);
            end
          end
        end
      end
      ST_PLAYER: begin
        if (sec_tick && timer_q != 4'd0) timer_d = timer_q - 4'd1;
        if (press[BTN_SEL] && shot_q[cur_idx]) err_d = 1'b1;
        // An accepted shot takes priority over the final timeout tick;
        // a rejected select does not save the player from forfeiting.
        if (press[BTN_SEL] && !shot_q[cur_idx]) begin
          shot_d[cur_idx] = 1'b1;
          hits_new = phits_q + (enemy_map[cur_idx] ? 3'd1 : 3'd0);
          phits_d  = hits_new;
          if (hits_new == count_q) begin
            state_d = ST_OVER;
            win_d   = WIN_PLAYER;
          end else begin
            state_d = ST_CPU;
          end
        end else if (sec_tick && timer_q == 4'd1) begin
          state_d = ST_CPU;
        end
      end
      ST_CPU: begin
        if (cpu_valid && cpu_i < 3'(BOARD_SIZE) && cpu_j < 3'(BOARD_SIZE)) begin
          cshot_d[cpu_idx] = 1'b1;
          hits_new = chits_q + ((!cshot_q[cpu_idx] && own_q[cpu_idx]) ? 3'd1 : 3'd0);
          chits_d  = hits_new;
          if (hits_new == count_q) begin
            state_d = ST_OVER;
            win_d   = WIN_CPU;
          end else begin
            state_d = ST_PLAYER;
            timer_d = 4'(TURN_SECS);
          end
        end
      end
      ST_OVER: begin
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d = (state_d == ST_CPU);
  end

  // State and output registers; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE; count_q <= '0; i_q     <= '0; j_q     <= '0;
      placed_q <= '0;     phits_q <= '0; chits_q <= '0; own_q   <= '0;
      shot_q  <= '0;      cshot_q <= '0; timer_q <= '0; win_q   <= WIN_NONE;
      err_q   <= 1'b0;    rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;  count_q <= count_d; i_q     <= i_d;     j_q     <= j_d;
      placed_q <= placed_d; phits_q <= phits_d; chits_q <= chits_d; own_q   <= own_d;
      shot_q  <= shot_d;   cshot_q <= cshot_d; timer_q <= timer_d; win_q   <= win_d;
      err_q   <= err_d;    rdy_q   <= rdy_d;
    end
  end

  assign cpu_ready    = rdy_q;
  assign i_cursor     = i_q;
  assign j_cursor     = j_q;
  assign ships_placed = placed_q;
  assign own_map      = own_q;
  assign shot_map     = shot_q;
  assign cpu_shot_map = cshot_q;
  assign player_hits  = phits_q;
  assign cpu_hits     = chits_q;
  assign turn_timer   = timer_q;
  assign state        = state_q;
  assign winner       = win_q;
  assign err_pulse    = err_q;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed scenario bench with an expectation queue drained by a monitor.
module tb_battleship_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        move_up = 1'b1, move_down = 1'b1, move_left = 1'b1, move_right = 1'b1;
  logic        btn_select = 1'b1, start = 1'b0, sec_tick = 1'b0, cpu_valid = 1'b0;
  logic [2:0]  amount_of_ships = 3'd0, cpu_i = 3'd0, cpu_j = 3'd0;
  logic [24:0] enemy_map = 25'd0;
  logic        cpu_ready, err_pulse;
  logic [2:0]  i_cursor, j_cursor, ships_placed, player_hits, cpu_hits, state;
  logic [24:0] own_map, shot_map, cpu_shot_map;
  logic [3:0]  turn_timer;
  logic [1:0]  winner;

  battleship_game_ctrl dut (
    .clk(clk), .rst(rst), .move_up(move_up), .move_down(move_down),
    .move_left(move_left), .move_right(move_right), .btn_select(btn_select),
    .start(start), .amount_of_ships(amount_of_ships), .sec_tick(sec_tick),
    .enemy_map(enemy_map), .cpu_valid(cpu_valid), .cpu_i(cpu_i), .cpu_j(cpu_j),
    .cpu_ready(cpu_ready), .i_cursor(i_cursor), .j_cursor(j_cursor),
    .ships_placed(ships_placed), .own_map(own_map), .shot_map(shot_map),
    .cpu_shot_map(cpu_shot_map), .player_hits(player_hits), .cpu_hits(cpu_hits),
    .turn_timer(turn_timer), .state(state), .winner(winner), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  localparam int S_STATE = 0, S_I = 1, S_J = 2, S_PLACED = 3, S_OWN = 4, S_SHOT = 5,
                 S_CSHOT = 6, S_PH = 7, S_CH = 8, S_TMR = 9, S_WIN = 10, S_ERR = 11,
                 S_RDY = 12;

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_STATE:  return 32'(state);
      S_I:      return 32'(i_cursor);
      S_J:      return 32'(j_cursor);
      S_PLACED: return 32'(ships_placed);
      S_OWN:    return 32'(own_map);
      S_SHOT:   return 32'(shot_map);
      S_CSHOT:  return 32'(cpu_shot_map);
      S_PH:     return 32'(player_hits);
      S_CH:     return 32'(cpu_hits);
      S_TMR:    return 32'(turn_timer);
      S_WIN:    return 32'(winner);
      S_ERR:    return 32'(err_pulse);
      S_RDY:    return 32'(cpu_ready);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: outputs are registered, so compare on the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = actual(e.sig);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  task automatic ex(input int sig, input logic [31:0] v, input string nm);
    exp_t t;
    t.sig = sig; t.val = v; t.name = nm;
    sb.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask bits: 0 up, 1 down, 2 left, 3 right, 4 select; press then release
  task automatic press(input logic [4:0] m);
    move_up = ~m[0]; move_down = ~m[1]; move_left = ~m[2];
    move_right = ~m[3]; btn_select = ~m[4];
    tick();
    {move_up, move_down, move_left, move_right, btn_select} = 5'b11111;
    tick();
  endtask

  task automatic cpu_shot(input logic [2:0] ci, input logic [2:0] cj);
    cpu_valid = 1'b1; cpu_i = ci; cpu_j = cj;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] n);
    start = 1'b1; amount_of_ships = n;
    tick();
    start = 1'b0;
  endtask

  localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LT = 5'b00100,
                         RT = 5'b01000, SEL = 5'b10000;

  initial begin
    enemy_map = 25'h0001040;       // cells 6 (1,1) and 12 (2,2)
    tick(); tick();
    ex(S_STATE, 0, "rst_state"); ex(S_I, 0, "rst_i"); ex(S_OWN, 0, "rst_own");
    ex(S_TMR, 0, "rst_timer"); ex(S_WIN, 0, "rst_winner"); ex(S_RDY, 0, "rst_ready");
    rst = 1'b0;
    tick();

    press(DN);
    ex(S_I, 0, "idle_move_ignored");
    pulse_start(3'd2);
    ex(S_STATE, 1, "start_to_place"); ex(S_PLACED, 0, "place_init");

    press(DN);
    ex(S_I, 1, "down_once");
    for (int k = 0; k < 5; k++) press(DN);
    ex(S_I, 4, "down_saturate");
    for (int k = 0; k < 4; k++) press(UP);
    ex(S_I, 0, "up_back_to_0");

    move_right = 1'b0;
    tick(); tick(); tick();
    ex(S_J, 1, "held_right_once");
    move_right = 1'b1;
    tick();
    press(LT);
    ex(S_J, 0, "left_back");

    press(SEL);
    ex(S_OWN, 32'h1, "place_00"); ex(S_PLACED, 1, "placed_1");
    btn_select = 1'b0;
    tick();
    btn_select = 1'b1;
    ex(S_ERR, 1, "dup_place_err"); ex(S_PLACED, 1, "dup_place_count");
    tick();
    ex(S_ERR, 0, "err_one_cycle");

    press(UP | DN | RT);
    ex(S_I, 0, "updown_cancel"); ex(S_J, 1, "diag_right");
    press(DN);
    ex(S_I, 1, "down_to_1");
    press(SEL);
    ex(S_PLACED, 2, "placed_2"); ex(S_OWN, 32'h41, "own_map_2");
    ex(S_STATE, 2, "to_player"); ex(S_TMR, 15, "timer_load");

    press(SEL);
    ex(S_SHOT, 32'h40, "shot_11"); ex(S_PH, 1, "phit_1");
    ex(S_STATE, 3, "to_cpu"); ex(S_RDY, 1, "cpu_ready_hi");
    press(DN);
    ex(S_I, 1, "cpu_turn_btn_ignored");

    cpu_shot(3'd5, 3'd0);
    ex(S_STATE, 3, "cpu_oob_stay"); ex(S_CSHOT, 0, "cpu_oob_map");
    cpu_shot(3'd0, 3'd0);
    ex(S_CH, 1, "cpu_hit_1"); ex(S_CSHOT, 1, "cpu_map_00");
    ex(S_STATE, 2, "cpu_to_player"); ex(S_TMR, 15, "timer_reload"); ex(S_RDY, 0, "cpu_ready_lo");

    press(SEL);
    ex(S_STATE, 2, "refire_stay"); ex(S_SHOT, 32'h40, "refire_map");
    press(RT);
    press(SEL);
    ex(S_SHOT, 32'hC0, "shot_12"); ex(S_PH, 1, "miss_no_hit"); ex(S_STATE, 3, "miss_to_cpu");
    cpu_shot(3'd0, 3'd0);
    ex(S_CH, 1, "cpu_repeat_miss"); ex(S_STATE, 2, "repeat_to_player");

    for (int k = 0; k < 14; k++) begin
      sec_tick = 1'b1;
      tick();
    end
    sec_tick = 1'b0;
    ex(S_TMR, 1, "timer_at_1"); ex(S_STATE, 2, "timer_still_player");
    sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0;
    ex(S_TMR, 0, "timer_zero"); ex(S_STATE, 3, "timeout_to_cpu"); ex(S_SHOT, 32'hC0, "timeout_no_shot");

    cpu_shot(3'd4, 3'd4);
    ex(S_CSHOT, 32'h1000001, "cpu_map_44"); ex(S_CH, 1, "cpu_miss_44"); ex(S_STATE, 2, "back_to_player");
    press(DN);
    ex(S_I, 2, "down_to_2");
    press(SEL);
    ex(S_PH, 2, "phit_2"); ex(S_STATE, 4, "game_over"); ex(S_WIN, 1, "player_wins");
    ex(S_SHOT, 32'h10C0, "final_shot_map");
    press(UP);
    ex(S_I, 2, "over_hold_cursor"); ex(S_STATE, 4, "over_hold_state");

    pulse_start(3'd3);
    ex(S_STATE, 0, "over_to_idle");
    pulse_start(3'd0);
    ex(S_STATE, 1, "restart_place"); ex(S_WIN, 0, "restart_winner");
    ex(S_OWN, 0, "restart_own"); ex(S_SHOT, 0, "restart_shot"); ex(S_I, 0, "restart_i");
    press(SEL);
    ex(S_STATE, 2, "clamp0_one_ship"); ex(S_PLACED, 1, "clamp0_placed");
    press(SEL);
    ex(S_SHOT, 1, "shot_00"); ex(S_PH, 0, "shot_00_miss"); ex(S_STATE, 3, "to_cpu_again");

    rst = 1'b1;
    tick();
    ex(S_STATE, 0, "midrst_state"); ex(S_RDY, 0, "midrst_ready"); ex(S_OWN, 0, "midrst_own");
    ex(S_SHOT, 0, "midrst_shot"); ex(S_CSHOT, 0, "midrst_cshot"); ex(S_PLACED, 0, "midrst_placed");
    ex(S_CH, 0, "midrst_chits"); ex(S_TMR, 0, "midrst_timer"); ex(S_WIN, 0, "midrst_winner");
    rst = 1'b0;
    tick();

    pulse_start(3'd7);
    press(SEL);
    ex(S_STATE, 1, "clamp7_still_place"); ex(S_PLACED, 1, "clamp7_placed");

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
